// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle RV32I sequencing controller: walks instructions through fetch/decode/execute/memory/writeback.
// Optional retired-instruction counter enabled by defining MCTRL_INSTRET_EN.
module multicycle_ctrl_fsm #(
  parameter bit          ZERO_WAIT   = 1'b0,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  op,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        AdrSrc,
  output logic        IRWrite,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        PCWrite,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic        illegal,
  output logic        mem_err,
  output logic [3:0]  state_dbg,
  output logic [31:0] instret
);

  localparam int unsigned WAIT_W    = 8;
  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(TIMEOUT_CYC);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    ALUWB    = 4'd7,
    EXECI    = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10,
    HALT     = 4'd11
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [WAIT_W-1:0]   r_wait;
  logic                r_illegal;
  logic                r_mem_err;
  logic                w_ready;
  logic                w_mem_state;
  logic                w_enter_mem;
  logic                w_timeout;
  logic                w_pc_update;
  logic                w_branch;
  logic                w_set_illegal;

  assign w_ready     = ZERO_WAIT ? 1'b1 : mem_ready;
  assign w_mem_state = (r_state == FETCH) || (r_state == MEMREAD) || (r_state == MEMWRITE);
  assign w_enter_mem = (w_state_next != r_state) &&
                       ((w_state_next == FETCH) || (w_state_next == MEMREAD) ||
                        (w_state_next == MEMWRITE));
  // 9-bit compare so a saturated counter cannot wrap back below the limit
  assign w_timeout   = (TIMEOUT_V != '0) && w_mem_state && !w_ready &&
                       (({1'b0, r_wait} + 9'd1) >= {1'b0, TIMEOUT_V});

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= FETCH;
      r_wait    <= '0;
      r_illegal <= 1'b0;
      r_mem_err <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_set_illegal) r_illegal <= 1'b1;
      if (w_timeout)     r_mem_err <= 1'b1;
      if (w_enter_mem)
        r_wait <= '0;
      else if (w_mem_state && !w_ready && (r_wait != '1))
        r_wait <= r_wait + WAIT_W'(1);
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_pc_update   = 1'b0;
    w_branch      = 1'b0;
    w_set_illegal = 1'b0;
    mem_req       = 1'b0;
    AdrSrc        = 1'b0;
    IRWrite       = 1'b0;
    MemWrite      = 1'b0;
    RegWrite      = 1'b0;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    ALUOp         = 2'b00;
    ResultSrc     = 2'b00;
    case (r_state)
      FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (w_ready) begin
          IRWrite      = 1'b1;
          w_pc_update  = 1'b1;
          w_state_next = DECODE;
        end
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: w_state_next = MEMADR;
          OP_R:         w_state_next = EXECR;
          OP_I:         w_state_next = EXECI;
          OP_JAL:       w_state_next = JAL;
          OP_BEQ:       w_state_next = BEQ;
          default: begin
            w_state_next  = HALT;
            w_set_illegal = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA      = 2'b10;
        ALUSrcB      = 2'b01;
        w_state_next = (op == OP_SW) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        if (w_ready) w_state_next = MEMWB;
      end
      MEMWB: begin
        ResultSrc    = 2'b01;
        RegWrite     = 1'b1;
        w_state_next = FETCH;
      end
      MEMWRITE: begin
        mem_req  = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (w_ready) w_state_next = FETCH;
      end
      EXECR: begin
        ALUSrcA      = 2'b10;
        ALUOp        = 2'b10;
        w_state_next = ALUWB;
      end
      EXECI: begin
        ALUSrcA      = 2'b10;
        ALUSrcB      = 2'b01;
        ALUOp        = 2'b10;
        w_state_next = ALUWB;
      end
      ALUWB: begin
        RegWrite     = 1'b1;
        w_state_next = FETCH;
      end
      JAL: begin
        ALUSrcA      = 2'b01;
        ALUSrcB      = 2'b10;
        w_pc_update  = 1'b1;
        w_state_next = ALUWB;
      end
      BEQ: begin
        ALUSrcA      = 2'b10;
        ALUOp        = 2'b01;
        w_branch     = 1'b1;
        w_state_next = FETCH;
      end
      HALT:    w_state_next = HALT;
      default: w_state_next = FETCH;
    endcase
    if (w_timeout) w_state_next = HALT;
  end

  assign PCWrite = (w_branch & zero) | w_pc_update;

  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  assign illegal   = r_illegal;
  assign mem_err   = r_mem_err;
  assign state_dbg = r_state;

`ifdef MCTRL_INSTRET_EN
  logic        w_retire;
  logic [31:0] r_instret;

  // Only writeback/store/branch states ever hand back to FETCH
  assign w_retire = (r_state != FETCH) && (w_state_next == FETCH);

  always_ff @(posedge clk) begin
    if (reset)         r_instret <= '0;
    else if (w_retire) r_instret <= r_instret + 32'd1;
  end

  assign instret = r_instret;
`else
  assign instret = '0;
`endif

endmodule
